// File: rtl/sensor_reset_sequencer.sv
// sensor_reset_sequencer
// Power-up and reset sequencer for a bank of BNO085-class IMUs on one clock.
// Holds every enabled sensor in reset, releases it, then issues a trigger pulse
// and watches each sensor's INT line for boot. Channels that stay silent are
// re-pulsed a bounded number of times before being flagged as failed. The
// per-channel ready bit gates the downstream SPI controllers.

module sensor_reset_sequencer #(
  parameter int NUM_SENSORS    = 2,
  parameter int T_LOW_CYCLES   = 6_000_000,
  parameter int T_HIGH_CYCLES  = 6_000_000,
  parameter int T_PULSE_CYCLES = 1000,
  parameter int T_BOOT_TIMEOUT = 300_000,
  parameter int MAX_RETRIES    = 3,
  parameter bit AUTO_START     = 1'b1,
  parameter int CNT_W          = 23,
  localparam int RETRY_W       = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_SENSORS-1:0] ch_en,
  input  logic [NUM_SENSORS-1:0] int_n,
  output logic [NUM_SENSORS-1:0] sensor_rst_n,
  output logic [NUM_SENSORS-1:0] sensor_ready,
  output logic [NUM_SENSORS-1:0] sensor_fail,
  output logic                   busy,
  output logic                   done,
  output logic [RETRY_W-1:0]     retry_cnt
);

  // Last timer value of each phase; a zero duration still occupies one cycle.
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'((T_LOW_CYCLES   > 0) ? T_LOW_CYCLES   - 1 : 0);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'((T_HIGH_CYCLES  > 0) ? T_HIGH_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'((T_PULSE_CYCLES > 0) ? T_PULSE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'((T_BOOT_TIMEOUT > 0) ? T_BOOT_TIMEOUT - 1 : 0);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    HOLD_LOW,
    HOLD_HIGH,
    PULSE,
    WAIT_INT,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         timer_q, timer_d;
  logic [CNT_W-1:0]         timer_inc;
  logic [NUM_SENSORS-1:0]   en_q, en_d;
  logic [NUM_SENSORS-1:0]   rst_out_q, rst_out_d;
  logic [NUM_SENSORS-1:0]   ready_q, ready_d;
  logic [NUM_SENSORS-1:0]   fail_q, fail_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [RETRY_W-1:0]       retry_q, retry_d;
  logic                     auto_q, auto_d;
  logic [NUM_SENSORS-1:0]   sync1_q, sync2_q;
  logic [NUM_SENSORS-1:0]   pending;
  logic [NUM_SENSORS-1:0]   int_seen;
  logic [NUM_SENSORS-1:0]   still_pending;
  logic                     launch;

  // Two-flop synchronizer for the asynchronous INT lines, idle-high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= int_n;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and registered-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    en_d          = en_q;
    rst_out_d     = rst_out_q;
    ready_d       = ready_q;
    fail_d        = fail_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    retry_d       = retry_q;
    auto_d        = auto_q;
    launch        = 1'b0;
    int_seen      = '0;
    pending       = en_q & ~ready_q & ~fail_q;
    still_pending = pending;
    timer_inc     = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        rst_out_d = '0;
        busy_d    = 1'b0;
        if (start || auto_q) begin
          launch = 1'b1;
        end
      end

      HOLD_LOW: begin
        if (timer_q == LOW_LAST) begin
          state_d   = HOLD_HIGH;
          timer_d   = '0;
          rst_out_d = en_q;
        end else begin
          timer_d = timer_inc;
        end
      end

      HOLD_HIGH: begin
        if (timer_q == HIGH_LAST) begin
          state_d   = PULSE;
          timer_d   = '0;
          rst_out_d = en_q & ~pending;
        end else begin
          timer_d = timer_inc;
        end
      end

      PULSE: begin
        if (timer_q == PULSE_LAST) begin
          state_d   = WAIT_INT;
          timer_d   = '0;
          rst_out_d = en_q;
        end else begin
          timer_d = timer_inc;
        end
      end

      WAIT_INT: begin
        int_seen      = pending & ~sync2_q;
        ready_d       = ready_q | int_seen;
        still_pending = pending & ~int_seen;
        if (still_pending == '0) begin
          state_d = DONE;
          timer_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (timer_q == BOOT_LAST) begin
          timer_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d   = retry_q + RETRY_W'(1);
            state_d   = PULSE;
            rst_out_d = en_q & ~still_pending;
          end else begin
            fail_d  = fail_q | still_pending;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_inc;
        end
      end

      DONE: begin
        rst_out_d = en_q;
        busy_d    = 1'b0;
        if (start) begin
          launch = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        timer_d   = '0;
        rst_out_d = '0;
        busy_d    = 1'b0;
      end
    endcase

    if (launch) begin
      state_d   = HOLD_LOW;
      timer_d   = '0;
      en_d      = ch_en;
      rst_out_d = '0;
      ready_d   = '0;
      fail_d    = '0;
      retry_d   = '0;
      busy_d    = 1'b1;
      auto_d    = 1'b0;
    end
  end

  // State, timer and status registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      en_q      <= '0;
      rst_out_q <= '0;
      ready_q   <= '0;
      fail_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      retry_q   <= '0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      en_q      <= en_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      retry_q   <= retry_d;
      auto_q    <= auto_d;
    end
  end

  assign sensor_rst_n = rst_out_q;
  assign sensor_ready = ready_q;
  assign sensor_fail  = fail_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_sensor_reset_sequencer.sv
// tb_sensor_reset_sequencer
// Drives whole reset/boot runs of a two-channel sequencer with short timings.
// Expected waveforms come from a phase/interval model built from the boot
// rules: fixed hold-low, hold-high and pulse windows, then boot-wait windows
// in which a channel is declared booted once its INT has been low two cycles.

module tb_sensor_reset_sequencer;

  localparam int N     = 2;
  localparam int TL    = 10;
  localparam int TH    = 10;
  localparam int TP    = 4;
  localparam int TO    = 20;
  localparam int MAXR  = 2;
  localparam int W0    = TL + TH + TP;
  localparam int MAXT  = 128;
  localparam int NEVER = 1000;
  localparam int NV    = 9;

  typedef struct {
    string      name;
    logic [1:0] en;
    int         l0;
    int         l1;
    int         start_at;
    logic [1:0] ready;
    logic [1:0] fail;
    int         retry;
    int         done_t;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] ch_en;
  logic [1:0] int_n;
  logic [1:0] sensor_rst_n;
  logic [1:0] sensor_ready;
  logic [1:0] sensor_fail;
  logic       busy;
  logic       done;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  logic [1:0] int_hist  [MAXT];
  logic [1:0] exp_rst   [MAXT];
  logic [1:0] exp_ready [MAXT];
  logic [1:0] exp_fail  [MAXT];
  logic       exp_busy  [MAXT];
  logic       exp_done  [MAXT];
  int         exp_retry [MAXT];

  vec_t vecs [NV];

  sensor_reset_sequencer #(
    .NUM_SENSORS   (N),
    .T_LOW_CYCLES  (TL),
    .T_HIGH_CYCLES (TH),
    .T_PULSE_CYCLES(TP),
    .T_BOOT_TIMEOUT(TO),
    .MAX_RETRIES   (MAXR),
    .AUTO_START    (1'b1),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ch_en       (ch_en),
    .int_n       (int_n),
    .sensor_rst_n(sensor_rst_n),
    .sensor_ready(sensor_ready),
    .sensor_fail (sensor_fail),
    .busy        (busy),
    .done        (done),
    .retry_cnt   (retry_cnt)
  );

  // Free-running 100 MHz bench clock.
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input string name, input logic [1:0] en, input int l0, input int l1,
                              input int start_at, input logic [1:0] ready, input logic [1:0] fail,
                              input int retry, input int done_t);
    vec_t v;
    v.name = name; v.en = en; v.l0 = l0; v.l1 = l1; v.start_at = start_at;
    v.ready = ready; v.fail = fail; v.retry = retry; v.done_t = done_t;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int t, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, t, actual, expected);
    end
  endtask

  // INT waveform: low from cycle l[i] onward, optional random low glitches before.
  task automatic gen_int(input int l0, input int l1, input bit noise);
    int l [2];
    l[0] = l0;
    l[1] = l1;
    for (int t = 0; t < MAXT; t++) begin
      for (int i = 0; i < N; i++) begin
        if (t >= l[i]) int_hist[t][i] = 1'b0;
        else if (noise && $urandom_range(0, 15) == 0) int_hist[t][i] = 1'b0;
        else int_hist[t][i] = 1'b1;
      end
    end
  endtask

  // Reference: walk boot-wait windows, recording detections, retry pulses and failures.
  task automatic build_model(input logic [1:0] en, output int done_t);
    int         w;
    int         retries;
    logic [1:0] pend;
    logic [1:0] fail_bits;
    int         det [2];
    int         p_start [$];
    logic [1:0] p_mask [$];
    w = W0;
    retries = 0;
    pend = en;
    fail_bits = 2'b00;
    det[0] = -1;
    det[1] = -1;
    done_t = -1;
    p_start.push_back(TL + TH);
    p_mask.push_back(2'b00);
    while (done_t < 0) begin
      for (int k = 0; k < TO; k++) begin
        int t;
        t = w + k;
        for (int i = 0; i < N; i++) begin
          if (pend[i] && t >= 2 && int_hist[t-2][i] == 1'b0) begin
            pend[i] = 1'b0;
            det[i] = t;
          end
        end
        if (pend == 2'b00) begin
          done_t = t;
          break;
        end
      end
      if (done_t < 0) begin
        if (retries < MAXR) begin
          retries++;
          p_start.push_back(w + TO);
          p_mask.push_back(en & ~pend);
          w = w + TO + TP;
        end else begin
          fail_bits = pend;
          done_t = w + TO - 1;
        end
      end
    end
    for (int t = 0; t < MAXT; t++) begin
      logic [1:0] r;
      r = (t < TL) ? 2'b00 : en;
      exp_retry[t] = 0;
      for (int p = 0; p < p_start.size(); p++) begin
        if (t >= p_start[p] && t < p_start[p] + TP) r = p_mask[p];
        if (p > 0 && t >= p_start[p]) exp_retry[t]++;
      end
      exp_rst[t]  = r;
      exp_busy[t] = (t <= done_t);
      exp_done[t] = (t == done_t + 1);
      for (int i = 0; i < N; i++) exp_ready[t][i] = (det[i] >= 0 && t > det[i]);
      exp_fail[t] = (t > done_t) ? fail_bits : 2'b00;
    end
  endtask

  // One full run; caller is at the negedge of the cycle before the launch edge.
  task automatic applyStimulus(input logic [1:0] en, input bit use_start, input bit noise,
                               input int start_at, output int done_t, output int done_seen);
    build_model(en, done_t);
    ch_en = en;
    start = use_start;
    int_n = 2'b11;
    done_seen = -1;
    for (int t = 0; t <= done_t + 3; t++) begin
      @(negedge clk);
      checkOutput("sensor_rst_n", t, 32'(sensor_rst_n), 32'(exp_rst[t]));
      checkOutput("busy", t, 32'(busy), 32'(exp_busy[t]));
      checkOutput("done", t, 32'(done), 32'(exp_done[t]));
      checkOutput("sensor_ready", t, 32'(sensor_ready), 32'(exp_ready[t]));
      checkOutput("sensor_fail", t, 32'(sensor_fail), 32'(exp_fail[t]));
      checkOutput("retry_cnt", t, 32'(retry_cnt), 32'(exp_retry[t]));
      if (done === 1'b1 && done_seen < 0) done_seen = t;
      start = (t == start_at) || (noise && t <= done_t && $urandom_range(0, 3) == 0);
      ch_en = noise ? 2'($urandom_range(0, 3)) : en;
      int_n = int_hist[t];
    end
  endtask

  initial begin
    int dt;
    int ds;
    vecs[0] = mk("boot_both",      2'b11, 29,    29,    15, 2'b11, 2'b00, 0, 31);
    vecs[1] = mk("ch0_fail",       2'b11, NEVER, 29,    -1, 2'b10, 2'b01, 2, 91);
    vecs[2] = mk("ch1_only",       2'b10, 0,     29,    -1, 2'b10, 2'b00, 0, 31);
    vecs[3] = mk("int_preload",    2'b11, 0,     0,     -1, 2'b11, 2'b00, 0, 24);
    vecs[4] = mk("edge_timeout",   2'b01, 41,    NEVER, -1, 2'b01, 2'b00, 0, 43);
    vecs[5] = mk("last_collision", 2'b01, 89,    NEVER, -1, 2'b01, 2'b00, 2, 91);
    vecs[6] = mk("all_off",        2'b00, 0,     0,     -1, 2'b00, 2'b00, 0, 24);
    vecs[7] = mk("retry_boot",     2'b11, 50,    29,    -1, 2'b11, 2'b00, 1, 52);
    vecs[8] = mk("fail_both",      2'b11, NEVER, NEVER, -1, 2'b00, 2'b11, 2, 91);

    rst_n = 1'b0;
    start = 1'b0;
    ch_en = 2'b11;
    int_n = 2'b11;
    repeat (2) @(negedge clk);
    checkOutput("reset.sensor_rst_n", 0, 32'(sensor_rst_n), 32'd0);
    checkOutput("reset.ready", 0, 32'(sensor_ready), 32'd0);
    checkOutput("reset.fail", 0, 32'(sensor_fail), 32'd0);
    checkOutput("reset.busy", 0, 32'(busy), 32'd0);
    checkOutput("reset.done", 0, 32'(done), 32'd0);
    checkOutput("reset.retry_cnt", 0, 32'(retry_cnt), 32'd0);
    rst_n = 1'b1;

    $display("[TB] table-driven runs");
    for (int v = 0; v < NV; v++) begin
      gen_int(vecs[v].l0, vecs[v].l1, 1'b0);
      applyStimulus(vecs[v].en, v != 0, 1'b0, vecs[v].start_at, dt, ds);
      checkOutput({vecs[v].name, ".ready"}, ds, 32'(sensor_ready), 32'(vecs[v].ready));
      checkOutput({vecs[v].name, ".fail"}, ds, 32'(sensor_fail), 32'(vecs[v].fail));
      checkOutput({vecs[v].name, ".retry"}, ds, 32'(retry_cnt), 32'(vecs[v].retry));
      checkOutput({vecs[v].name, ".done_cycle"}, ds, 32'(ds), 32'(vecs[v].done_t + 1));
    end

    $display("[TB] reset abort during retry pulse");
    gen_int(NEVER, 29, 1'b0);
    ch_en = 2'b11;
    int_n = 2'b11;
    start = 1'b1;
    for (int t = 0; t <= 45; t++) begin
      @(negedge clk);
      start = 1'b0;
      int_n = int_hist[t];
    end
    checkOutput("abort.pre_rst_n", 45, 32'(sensor_rst_n), 32'(2'b10));
    checkOutput("abort.pre_busy", 45, 32'(busy), 32'd1);
    checkOutput("abort.pre_retry", 45, 32'(retry_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort.rst_n", 45, 32'(sensor_rst_n), 32'd0);
    checkOutput("abort.busy", 45, 32'(busy), 32'd0);
    checkOutput("abort.ready", 45, 32'(sensor_ready), 32'd0);
    checkOutput("abort.retry", 45, 32'(retry_cnt), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("abort.held_busy", 47, 32'(busy), 32'd0);
    checkOutput("abort.held_rst_n", 47, 32'(sensor_rst_n), 32'd0);
    rst_n = 1'b1;
    gen_int(29, 29, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0, -1, dt, ds);
    checkOutput("abort.rerun_ready", ds, 32'(sensor_ready), 32'(2'b11));
    checkOutput("abort.rerun_done_cycle", ds, 32'(ds), 32'd32);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      int l0;
      int l1;
      logic [1:0] en;
      en = 2'($urandom_range(0, 3));
      l0 = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(20, 100));
      l1 = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(20, 100));
      gen_int(l0, l1, 1'b1);
      applyStimulus(en, 1'b1, 1'b1, -1, dt, ds);
      checkOutput("rand.done_cycle", ds, 32'(ds), 32'(dt + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
